// File: rtl/vga_scan_gen.sv
// vga_scan_gen -- VGA raster timing generator.
//
// Divides the system clock by two to form the pixel clock and walks a
// DrawX/DrawY raster across the full line/frame (visible plus blanking).
// Sync, blank, frame_tick and frame_count are all registered on the same
// Clk edge that moves the raster, so they always describe the current pixel.
//
// Ports
//   Clk          in   system clock; all state changes on its rising edge
//   Reset_n      in   synchronous active-low reset
//   vga_clk      out  pixel clock (Clk/2, registered toggle)
//   hs           out  horizontal sync, active low
//   vs           out  vertical sync, active low
//   blank        out  1 inside the visible region, 0 during blanking
//   DrawX        out  current pixel column, 0..H_TOTAL-1
//   DrawY        out  current pixel row, 0..V_TOTAL-1
//   frame_tick   out  one-Clk pulse on entry to vertical blanking
//   frame_count  out  completed visible frames, mod 256
module vga_scan_gen #(
    parameter int H_VIS        = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_VIS        = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       vga_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    localparam logic [9:0] H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0] H_SS_W    = 10'(H_SYNC_START);
    localparam logic [9:0] H_SE_W    = 10'(H_SYNC_END);
    localparam logic [9:0] H_LAST_W  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_W   = 10'(V_VIS);
    localparam logic [9:0] V_SS_W    = 10'(V_SYNC_START);
    localparam logic [9:0] V_SE_W    = 10'(V_SYNC_END);
    localparam logic [9:0] V_LAST_W  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VLAST_W = 10'(V_VIS - 1);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       x_wrap;
    logic       enter_vblank;

    // Next raster position; sync/blank are decoded from it so the
    // registered flags line up with the registered counters.
    always_comb begin
        x_wrap       = (DrawX == H_LAST_W);
        x_nxt        = x_wrap ? 10'd0 : DrawX + 10'd1;
        y_nxt        = DrawY;
        enter_vblank = 1'b0;
        if (x_wrap) begin
            y_nxt        = (DrawY == V_LAST_W) ? 10'd0 : DrawY + 10'd1;
            enter_vblank = (DrawY == V_VLAST_W);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vga_clk     <= 1'b0;
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_tick  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            vga_clk    <= ~vga_clk;
            frame_tick <= 1'b0;
            // Pixel step happens while vga_clk is high, so the raster is
            // stable across every vga_clk rising edge.
            if (vga_clk) begin
                DrawX <= x_nxt;
                DrawY <= y_nxt;
                hs    <= ~((x_nxt >= H_SS_W) && (x_nxt < H_SE_W));
                vs    <= ~((y_nxt >= V_SS_W) && (y_nxt < V_SE_W));
                blank <= (x_nxt < H_VIS_W) && (y_nxt < V_VIS_W);
                if (enter_vblank) begin
                    frame_tick  <= 1'b1;
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
module tb_vga_scan_gen;

    // Reduced raster for the small instance so 256 frames fit in the run.
    localparam int S_HV = 8,  S_HSS = 9,  S_HSE = 11, S_HT = 12;
    localparam int S_VV = 5,  S_VSS = 6,  S_VSE = 7,  S_VT = 8;
    localparam int D_HV = 640, D_HSS = 656, D_HSE = 752, D_HT = 800;
    localparam int D_VV = 480, D_VSS = 490, D_VSE = 492, D_VT = 525;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    logic       vga_clk_s, hs_s, vs_s, blank_s, tick_s;
    logic [9:0] x_s, y_s;
    logic [7:0] cnt_s;
    logic       vga_clk_d, hs_d, vs_d, blank_d, tick_d;
    logic [9:0] x_d, y_d;
    logic [7:0] cnt_d;

    int  checks = 0;
    int  errors = 0;
    longint ncyc = 0;

    always #5 Clk = ~Clk;

    vga_scan_gen #(
        .H_VIS(S_HV), .H_SYNC_START(S_HSS), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
        .V_VIS(S_VV), .V_SYNC_START(S_VSS), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT)
    ) dut_s (
        .Clk(Clk), .Reset_n(Reset_n), .vga_clk(vga_clk_s), .hs(hs_s), .vs(vs_s),
        .blank(blank_s), .DrawX(x_s), .DrawY(y_s), .frame_tick(tick_s),
        .frame_count(cnt_s)
    );

    vga_scan_gen dut_d (
        .Clk(Clk), .Reset_n(Reset_n), .vga_clk(vga_clk_d), .hs(hs_d), .vs(vs_d),
        .blank(blank_d), .DrawX(x_d), .DrawY(y_d), .frame_tick(tick_d),
        .frame_count(cnt_d)
    );

    // Clk edges elapsed since the last edge that saw reset asserted.
    always @(posedge Clk) ncyc <= Reset_n ? ncyc + 1 : 0;

    // Reference: everything follows from the number of edges since reset.
    // Pixel steps = n/2; raster position is that count folded by line/frame.
    function automatic logic [32:0] model(input longint n,
        input int hv, input int hss, input int hse, input int ht,
        input int vv, input int vss, input int vse, input int vt);
        longint steps, fr, t0, x, y, cnt;
        logic vc, h, v, b, t;
        steps = n / 2;
        fr    = longint'(ht) * vt;
        t0    = longint'(vv) * ht;
        x     = steps % ht;
        y     = (steps / ht) % vt;
        vc    = (n % 2) == 1;
        h     = !(x >= hss && x < hse);
        v     = !(y >= vss && y < vse);
        b     = (x < hv) && (y < vv);
        t     = ((n % 2) == 0) && (steps >= t0) && ((steps % fr) == t0);
        cnt   = (steps >= t0) ? (((steps - t0) / fr + 1) % 256) : 0;
        return {vc, h, v, b, 10'(x), 10'(y), t, 8'(cnt)};
    endfunction

    task automatic test_reset();
        logic [32:0] rst_val;
        rst_val = {1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 8'd0};
        Reset_n = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if ({vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s} !== rst_val) begin
                errors++;
                $display("FAIL reset_small: got %h want %h",
                         {vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s}, rst_val);
            end
            checks++;
            if ({vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d} !== rst_val) begin
                errors++;
                $display("FAIL reset_default: got %h want %h",
                         {vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d}, rst_val);
            end
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (vga_clk_d !== 1'b1 || x_d !== 10'd0) begin
            errors++;
            $display("FAIL first_edge: vga_clk=%b DrawX=%0d want 1/0", vga_clk_d, x_d);
        end
        @(negedge Clk);
        checks++;
        if (vga_clk_d !== 1'b0 || x_d !== 10'd1 || x_s !== 10'd1) begin
            errors++;
            $display("FAIL first_step: vga_clk=%b DrawX=%0d/%0d want 0/1/1", vga_clk_d, x_d, x_s);
        end
    endtask

    // Two full default lines: sync placement, blanking, line wrap.
    task automatic test_line();
        logic [32:0] exp_d, exp_s;
        int hs_low = 0;
        int hs_min = 1023, hs_max = 0;
        repeat (3300) begin
            @(negedge Clk);
            exp_d = model(ncyc, D_HV, D_HSS, D_HSE, D_HT, D_VV, D_VSS, D_VSE, D_VT);
            exp_s = model(ncyc, S_HV, S_HSS, S_HSE, S_HT, S_VV, S_VSS, S_VSE, S_VT);
            checks++;
            if ({vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d} !== exp_d) begin
                errors++;
                $display("FAIL line_default n=%0d: got %h want %h", ncyc,
                         {vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d}, exp_d);
            end
            checks++;
            if ({vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s} !== exp_s) begin
                errors++;
                $display("FAIL line_small n=%0d: got %h want %h", ncyc,
                         {vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s}, exp_s);
            end
            if (y_d == 10'd0 && hs_d == 1'b0) begin
                hs_low++;
                if (x_d < hs_min) hs_min = x_d;
                if (x_d > hs_max) hs_max = x_d;
            end
            if (ncyc == 1600) begin
                checks++;
                if (x_d !== 10'd0 || y_d !== 10'd1) begin
                    errors++;
                    $display("FAIL line_wrap: DrawX=%0d DrawY=%0d want 0/1", x_d, y_d);
                end
            end
        end
        checks++;
        if (hs_low != 2 * (D_HSE - D_HSS) || hs_min != D_HSS || hs_max != D_HSE - 1) begin
            errors++;
            $display("FAIL hs_pulse: clk=%0d x=%0d..%0d want %0d clk x=%0d..%0d",
                     hs_low, hs_min, hs_max, 2 * (D_HSE - D_HSS), D_HSS, D_HSE - 1);
        end
    endtask

    // 256+ small frames: tick spacing, count wrap, vs width per frame.
    task automatic test_frames();
        logic [32:0] exp_s, exp_d;
        longint last_tick = -1;
        int ticks = 0;
        int vs_low = 0;
        int base_cnt;
        base_cnt = cnt_s;
        repeat (S_HT * S_VT * 2 * 257) begin
            @(negedge Clk);
            exp_s = model(ncyc, S_HV, S_HSS, S_HSE, S_HT, S_VV, S_VSS, S_VSE, S_VT);
            exp_d = model(ncyc, D_HV, D_HSS, D_HSE, D_HT, D_VV, D_VSS, D_VSE, D_VT);
            checks++;
            if ({vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s} !== exp_s) begin
                errors++;
                $display("FAIL frame_small n=%0d: got %h want %h", ncyc,
                         {vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s}, exp_s);
            end
            checks++;
            if ({vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d} !== exp_d) begin
                errors++;
                $display("FAIL frame_default n=%0d: got %h want %h", ncyc,
                         {vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d}, exp_d);
            end
            if (vs_s == 1'b0) vs_low++;
            if (tick_s === 1'b1) begin
                ticks++;
                checks++;
                if (cnt_s !== 8'((base_cnt + ticks) % 256) || y_s !== 10'(S_VV) || x_s !== 10'd0) begin
                    errors++;
                    $display("FAIL tick_state: cnt=%0d x=%0d y=%0d want %0d/0/%0d",
                             cnt_s, x_s, y_s, (base_cnt + ticks) % 256, S_VV);
                end
                if (last_tick >= 0) begin
                    checks++;
                    if (ncyc - last_tick != 2 * S_HT * S_VT) begin
                        errors++;
                        $display("FAIL tick_spacing: got %0d want %0d",
                                 ncyc - last_tick, 2 * S_HT * S_VT);
                    end
                    checks++;
                    if (vs_low != 2 * S_HT * (S_VSE - S_VSS)) begin
                        errors++;
                        $display("FAIL vs_width: got %0d want %0d",
                                 vs_low, 2 * S_HT * (S_VSE - S_VSS));
                    end
                end
                last_tick = ncyc;
                vs_low = 0;
            end
        end
        checks++;
        if (ticks < 256) begin
            errors++;
            $display("FAIL tick_total: got %0d want >=256", ticks);
        end
    endtask

    // Random reset pulses at random raster positions; timing must restart.
    task automatic test_mid_reset();
        logic [32:0] exp_s, exp_d;
        int run_len, rst_len;
        for (int it = 0; it < 8; it++) begin
            run_len = $urandom_range(600, 40);
            rst_len = $urandom_range(3, 1);
            repeat (run_len) begin
                @(negedge Clk);
                exp_s = model(ncyc, S_HV, S_HSS, S_HSE, S_HT, S_VV, S_VSS, S_VSE, S_VT);
                exp_d = model(ncyc, D_HV, D_HSS, D_HSE, D_HT, D_VV, D_VSS, D_VSE, D_VT);
                checks++;
                if ({vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s} !== exp_s) begin
                    errors++;
                    $display("FAIL midrst_small n=%0d: got %h want %h", ncyc,
                             {vga_clk_s, hs_s, vs_s, blank_s, x_s, y_s, tick_s, cnt_s}, exp_s);
                end
                checks++;
                if ({vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d} !== exp_d) begin
                    errors++;
                    $display("FAIL midrst_default n=%0d: got %h want %h", ncyc,
                             {vga_clk_d, hs_d, vs_d, blank_d, x_d, y_d, tick_d, cnt_d}, exp_d);
                end
            end
            Reset_n = 1'b0;
            repeat (rst_len) begin
                @(negedge Clk);
                checks++;
                if ({vga_clk_s, x_s, y_s, hs_s, vs_s, blank_s, tick_s, cnt_s} !==
                    {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
                    errors++;
                    $display("FAIL midrst_values: vga_clk=%b x=%0d y=%0d hs=%b vs=%b blank=%b tick=%b cnt=%0d",
                             vga_clk_s, x_s, y_s, hs_s, vs_s, blank_s, tick_s, cnt_s);
                end
            end
            Reset_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
